// File: rtl/hgcal_fc_orbit_tracker.sv
// Receive-side orbit tracker: follows BX/orbit from decoded OS/OCR fast commands,
// acquires lock after consecutive aligned OS strobes and reports misalignment.
module hgcal_fc_orbit_tracker #(
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic        clk40,
  input  logic        reset,
  input  logic        enable,
  input  logic        os_strobe,
  input  logic        ocr_strobe,
  input  logic [11:0] bx_target,
  input  logic [11:0] orbit_length,
  output logic [11:0] bx_count,
  output logic [31:0] orbit_count,
  output logic        locked,
  output logic        os_err,
  output logic [15:0] err_count,
  output logic        cfg_err
);

  localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int MW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ALIGNING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   good_q, good_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [11:0]     bx_q, bx_d;
  logic [31:0]     orbit_q, orbit_d;
  logic [15:0]     err_count_q, err_count_d;
  logic            locked_q, locked_d;
  logic            os_err_q, os_err_d;

  logic [11:0]     last_bx;
  logic [11:0]     bx_realign;
  logic            bx_wrap;
  logic            os_hit;
  logic            ocr_hit;
  logic            at_slot;
  logic            aligned;
  logic            realign;

  assign cfg_err = (bx_target >= orbit_length);

  always_comb begin
    last_bx    = orbit_length - 12'd1;
    bx_wrap    = (bx_q == last_bx) || (bx_q >= orbit_length);
    // The strobe cycle itself counts as bx_target, so the next cycle is one past it.
    bx_realign = (bx_target == last_bx) ? 12'd0 : bx_target + 12'd1;
    os_hit     = enable && os_strobe;
    ocr_hit    = enable && ocr_strobe;
    at_slot    = (bx_q == bx_target) && !cfg_err;
    aligned    = os_hit && at_slot;
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    miss_d   = miss_q;
    realign  = 1'b0;
    os_err_d = 1'b0;

    if (!enable) begin
      state_d = ST_UNLOCKED;
      good_d  = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          if (os_hit) begin
            realign = 1'b1;
            good_d  = GW'(1);
            state_d = ST_ALIGNING;
          end
        end

        ST_ALIGNING: begin
          if (aligned) begin
            good_d = good_q + GW'(1);
            if (int'(good_q) + 1 >= LOCK_COUNT) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (os_hit) begin
            realign  = 1'b1;
            good_d   = GW'(1);
            os_err_d = 1'b1;
          end
        end

        ST_LOCKED: begin
          if (aligned) begin
            miss_d = '0;
          end else if (os_hit) begin
            realign  = 1'b1;
            good_d   = GW'(1);
            os_err_d = 1'b1;
            state_d  = ST_ALIGNING;
          end else if (at_slot) begin
            // Expected OS slot passed with no strobe.
            if (int'(miss_q) + 1 >= MISS_LIMIT) begin
              state_d  = ST_UNLOCKED;
              miss_d   = '0;
              good_d   = '0;
              os_err_d = 1'b1;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end

        default: begin
          state_d = ST_UNLOCKED;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    if (realign) begin
      bx_d = bx_realign;
    end else if (bx_wrap) begin
      bx_d = 12'd0;
    end else begin
      bx_d = bx_q + 12'd1;
    end

    // OCR wins over a wrap in the same cycle; a realign landing on 0 is also a wrap.
    if (ocr_hit) begin
      orbit_d = 32'd0;
    end else if (enable && (bx_d == 12'd0)) begin
      orbit_d = orbit_q + 32'd1;
    end else begin
      orbit_d = orbit_q;
    end

    if (os_err_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_UNLOCKED;
      good_q      <= '0;
      miss_q      <= '0;
      bx_q        <= '0;
      orbit_q     <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      os_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      bx_q        <= bx_d;
      orbit_q     <= orbit_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      os_err_q    <= os_err_d;
    end
  end

  assign bx_count    = bx_q;
  assign orbit_count = orbit_q;
  assign locked      = locked_q;
  assign os_err      = os_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_hgcal_fc_orbit_tracker.sv
// Scoreboard bench for hgcal_fc_orbit_tracker: expectations are queued with each
// stimulus step and compared against the outputs one step later.
module tb_hgcal_fc_orbit_tracker;

  logic        clk40 = 1'b0;
  logic        reset;
  logic        enable;
  logic        os_strobe;
  logic        ocr_strobe;
  logic [11:0] bx_target;
  logic [11:0] orbit_length;
  logic [11:0] bx_count;
  logic [31:0] orbit_count;
  logic        locked;
  logic        os_err;
  logic [15:0] err_count;
  logic        cfg_err;

  hgcal_fc_orbit_tracker #(.LOCK_COUNT(3), .MISS_LIMIT(2)) dut (
    .clk40       (clk40),
    .reset       (reset),
    .enable      (enable),
    .os_strobe   (os_strobe),
    .ocr_strobe  (ocr_strobe),
    .bx_target   (bx_target),
    .orbit_length(orbit_length),
    .bx_count    (bx_count),
    .orbit_count (orbit_count),
    .locked      (locked),
    .os_err      (os_err),
    .err_count   (err_count),
    .cfg_err     (cfg_err)
  );

  always #5 clk40 = ~clk40;

  localparam int SEL_BX  = 0;
  localparam int SEL_ORB = 1;
  localparam int SEL_LCK = 2;
  localparam int SEL_ERR = 3;
  localparam int SEL_CNT = 4;
  localparam int SEL_CFG = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_BX:  return {20'd0, bx_count};
      SEL_ORB: return orbit_count;
      SEL_LCK: return {31'd0, locked};
      SEL_ERR: return {31'd0, os_err};
      SEL_CNT: return {16'd0, err_count};
      SEL_CFG: return {31'd0, cfg_err};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic ex(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic step(input logic os, input logic ocr);
    os_strobe  = os;
    ocr_strobe = ocr;
    tick();
    os_strobe  = 1'b0;
    ocr_strobe = 1'b0;
    drain();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    os_strobe    = 1'b0;
    ocr_strobe   = 1'b0;
    orbit_length = 12'd3564;
    bx_target    = 12'd3500;

    #3;
    ex("rst_bx", SEL_BX, 0);   ex("rst_orb", SEL_ORB, 0); ex("rst_lck", SEL_LCK, 0);
    ex("rst_err", SEL_ERR, 0); ex("rst_cnt", SEL_CNT, 0); ex("rst_cfg", SEL_CFG, 0);
    drain();
    tick();
    reset  = 1'b1;
    enable = 1'b1;

    // Acquisition at arbitrary phase
    run(1234);
    ex("acq1_bx", SEL_BX, 3501); ex("acq1_lck", SEL_LCK, 0); ex("acq1_err", SEL_ERR, 0);
    step(1, 0);
    run(3563);
    ex("acq2_lck", SEL_LCK, 0); ex("acq2_err", SEL_ERR, 0);
    step(1, 0);
    run(3563);
    ex("acq3_lck", SEL_LCK, 1); ex("acq3_err", SEL_ERR, 0); ex("acq3_cnt", SEL_CNT, 0);
    ex("acq3_bx", SEL_BX, 3501);
    step(1, 0);

    // Slip: OS one cycle early
    run(3562);
    ex("slip_err", SEL_ERR, 1); ex("slip_lck", SEL_LCK, 0); ex("slip_bx", SEL_BX, 3501);
    ex("slip_cnt", SEL_CNT, 1);
    step(1, 0);
    ex("slip_pulse", SEL_ERR, 0);
    step(0, 0);
    run(3562);
    ex("relock1_lck", SEL_LCK, 0);
    step(1, 0);
    run(3563);
    step(1, 0);
    run(3563);
    ex("relock3_lck", SEL_LCK, 1); ex("relock3_cnt", SEL_CNT, 1);
    step(1, 0);

    // Loss: OS stops
    run(3563);
    ex("miss1_lck", SEL_LCK, 1); ex("miss1_err", SEL_ERR, 0);
    step(0, 0);
    run(3563);
    ex("miss2_lck", SEL_LCK, 0); ex("miss2_err", SEL_ERR, 1); ex("miss2_cnt", SEL_CNT, 2);
    step(0, 0);
    ex("miss2_pulse", SEL_ERR, 0);
    step(0, 0);
    ex("unl_os_err", SEL_ERR, 0); ex("unl_os_cnt", SEL_CNT, 2);
    step(1, 0);

    // Short orbit: length 4, target 3 (last BX)
    orbit_length = 12'd4;
    bx_target    = 12'd3;
    enable       = 1'b0;
    step(0, 0);
    enable = 1'b1;
    run(1);
    ex("edge_realign_bx", SEL_BX, 0); ex("edge_lck", SEL_LCK, 0);
    step(1, 0);
    run(3); step(1, 0);
    run(3);
    ex("short_lck", SEL_LCK, 1); ex("short_bx", SEL_BX, 0);
    step(1, 0);
    ex("ocr_orb", SEL_ORB, 0); ex("ocr_bx", SEL_BX, 1);
    step(0, 1);
    run(2);
    ex("wrap_orb", SEL_ORB, 1); ex("wrap_lck", SEL_LCK, 1);
    step(1, 0);
    run(3);
    ex("ocr_at_wrap_orb", SEL_ORB, 0); ex("os_ocr_lck", SEL_LCK, 1); ex("os_ocr_err", SEL_ERR, 0);
    step(1, 1);
    run(3);
    ex("wrap2_orb", SEL_ORB, 1);
    step(1, 0);
    run(1);
    ex("mis_ocr_err", SEL_ERR, 1); ex("mis_ocr_lck", SEL_LCK, 0);
    ex("mis_ocr_bx", SEL_BX, 0);   ex("mis_ocr_orb", SEL_ORB, 0); ex("mis_ocr_cnt", SEL_CNT, 3);
    step(1, 1);
    run(3); step(1, 0);
    run(3);
    ex("relock_short_lck", SEL_LCK, 1); ex("relock_short_orb", SEL_ORB, 2);
    step(1, 0);

    // Enable drop while locked
    enable = 1'b0;
    ex("dis_lck", SEL_LCK, 0); ex("dis_err", SEL_ERR, 0); ex("dis_bx", SEL_BX, 1);
    step(0, 0);
    run(2);
    ex("dis_orb_hold", SEL_ORB, 2); ex("dis_bx_run", SEL_BX, 0); ex("dis_lck2", SEL_LCK, 0);
    ex("dis_err2", SEL_ERR, 0); ex("dis_cnt", SEL_CNT, 3);
    step(1, 1);

    // Config error: target == length
    enable    = 1'b1;
    bx_target = 12'd4;
    ex("cfg_err_hi", SEL_CFG, 1); ex("cfg_first_err", SEL_ERR, 0);
    step(1, 0);
    for (int i = 0; i < 4; i++) begin
      run(3);
      ex("cfg_os_err", SEL_ERR, 1); ex("cfg_no_lock", SEL_LCK, 0);
      step(1, 0);
    end
    ex("cfg_cnt", SEL_CNT, 7);
    step(0, 0);

    // Saturation of err_count
    force dut.err_count_q = 16'hFFFF;
    #1;
    release dut.err_count_q;
    ex("sat_err", SEL_ERR, 1); ex("sat_cnt", SEL_CNT, 16'hFFFF);
    step(1, 0);

    // Async reset mid-orbit while locked
    bx_target = 12'd3;
    step(0, 0);
    run(3); step(1, 0);
    run(3);
    ex("pre_rst_lck", SEL_LCK, 1);
    step(1, 0);
    step(0, 0);
    #3;
    reset = 1'b0;
    #1;
    ex("arst_bx", SEL_BX, 0);   ex("arst_orb", SEL_ORB, 0); ex("arst_lck", SEL_LCK, 0);
    ex("arst_err", SEL_ERR, 0); ex("arst_cnt", SEL_CNT, 0);
    drain();
    #1;
    reset = 1'b1;
    ex("post_rst_bx", SEL_BX, 1); ex("post_rst_lck", SEL_LCK, 0);
    step(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hgcal_fc_orbit_tracker.md
HGCAL_FC_ORBIT_TRACKER -- requirements
Module: hgcal_fc_orbit_tracker

Purpose: receive-side counterpart of the fast-control orbit-sync manager. Tracks BX and orbit from decoded OS/OCR commands, acquires and holds lock, and flags misalignment.

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 3: number of consecutive aligned OS strobes needed to declare lock.
REQ-002 SHALL have parameter MISS_LIMIT, default 2: number of consecutive missing OS strobes in LOCKED that forces loss of lock.
REQ-003 Ports:
- clk40 in 1: 40 MHz clock; the block's only clock.
- reset in 1: asynchronous, active-low reset.
- enable in 1: tracking enable.
- os_strobe in 1: decoded orbit-sync command, one-cycle pulse.
- ocr_strobe in 1: decoded orbit-count-reset command, one-cycle pulse.
- bx_target in 12: BX number at which OS/OCR are issued.
- orbit_length in 12: BX per orbit (nominal 3564), must be >= 2.
- bx_count out 12: local BX number of the current cycle.
- orbit_count out 32: local orbit number.
- locked out 1: high while in LOCKED.
- os_err out 1: one-cycle pulse on a misaligned OS or on loss of lock.
- err_count out 16: count of os_err pulses, saturating.
- cfg_err out 1: combinational; high when bx_target >= orbit_length.

Function
REQ-004 bx_count SHALL advance every cycle: 0 when bx_count == orbit_length-1 or bx_count >= orbit_length, else bx_count+1. It free-runs regardless of enable.
REQ-005 "Realign" SHALL mean loading bx_count next = (bx_target == orbit_length-1) ? 0 : bx_target+1, so the strobe cycle is treated as BX bx_target.
REQ-006 An OS SHALL be "aligned" when os_strobe=1, bx_count == bx_target and cfg_err=0.
REQ-007 The FSM SHALL have three states: UNLOCKED, ALIGNING, LOCKED. It keeps an internal good counter and a miss counter.
REQ-008 In UNLOCKED, on os_strobe: realign, set good counter to 1, go to ALIGNING. No os_err.
REQ-009 In ALIGNING:
- aligned OS: increment good counter; on reaching LOCK_COUNT, go to LOCKED and clear the miss counter.
- misaligned OS: realign, set good counter to 1, pulse os_err, stay in ALIGNING.
REQ-010 In LOCKED:
- aligned OS: clear the miss counter.
- misaligned OS: realign, set good counter to 1, pulse os_err, go to ALIGNING.
REQ-011 In LOCKED, when bx_count == bx_target and os_strobe=0, the miss counter SHALL increment. On reaching MISS_LIMIT: go to UNLOCKED, pulse os_err, no realign.
REQ-012 locked SHALL be registered and equal (state == LOCKED), updating on the same edge as the state.
REQ-013 orbit_count SHALL increment by 1 (wrapping at 2^32) on each bx_count wrap to 0, including a wrap caused by realign.
REQ-014 On ocr_strobe, orbit_count next SHALL be 0, in every state. OCR takes priority over a simultaneous wrap increment. OCR does not affect bx_count or the FSM.
REQ-015 If os_strobe and ocr_strobe arrive in the same cycle, both SHALL be processed per REQ-008..014.
REQ-016 err_count SHALL increment on each os_err pulse and saturate at 16'hFFFF.
REQ-017 While enable=0:
- FSM held in UNLOCKED; good and miss counters cleared.
- os_strobe and ocr_strobe ignored.
- orbit_count holds (no wrap increments).
- os_err=0.
REQ-018 If enable falls while LOCKED: go to UNLOCKED on the next edge, without an os_err pulse.
REQ-019 While cfg_err=1: every os_strobe is misaligned and no miss is counted.

Reset
REQ-020 reset low SHALL asynchronously force: bx_count=0, orbit_count=0, err_count=0, state UNLOCKED, good and miss counters 0, locked=0, os_err=0.
REQ-021 Reset asserted mid-lock SHALL lose lock immediately. After release, operation resumes from REQ-020 values on the first clk40 edge.

Verification
REQ-022 Acquisition: orbit_length=3564, bx_target=3500, OS every 3564 cycles, first OS at arbitrary phase -> bx_count=3501 in the cycle after the first OS; locked=1 after the 3rd OS; os_err never pulses.
REQ-023 Slip: while locked, one OS arrives 1 cycle early -> os_err single pulse, err_count +1, locked=0, bx realigned; locked=1 again after 3 further aligned OS.
REQ-024 Loss: while locked, OS stops -> after 2 expected slots locked=0 and os_err pulses once. Then a misaligned OS in UNLOCKED -> no os_err.
REQ-025 Orbit/OCR: orbit_length=4, bx_target=3, locked -> orbit_count +1 per 4 cycles. OCR at the wrap cycle -> orbit_count=0, not 1. Simultaneous OS+OCR -> both take effect.
REQ-026 Boundaries:
- bx_target=orbit_length-1 realign -> bx_count=0 next.
- bx_target=orbit_length -> cfg_err=1 and lock is never reached.
- Force err_count to 16'hFFFF, then one more error -> stays 16'hFFFF.
- Async reset pulse mid-orbit -> all outputs 0 with no clock edge.
